spi_dev_fwrite: RTL

// FPGA->ESP32 file write engine; the write-direction counterpart of spi_dev_fread.

---
 rtl/spi_dev_fwrite.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spi_dev_fwrite.sv
// spi_dev_fwrite: FPGA->ESP32 file write engine; buffers a payload and serves header+payload on GET, then waits for ACK status
// Ports:
//   clk, rst_n                     system clock, async active-low reset
//   i_pw_* / o_pw_*                protocol wrapper: command/data in, MISO read channel (req/gnt/rdata/rstb), irq
//   i_req_* / o_req_ready          request post: file id, offset, length-1
//   i_wr_* / o_wr_ready            payload byte stream into the buffer
//   o_resp_done / o_resp_err       completion pulse and nonzero-status flag
module spi_dev_fwrite #(
  parameter logic [7:0] CMD_GET   = 8'hf9,
  parameter logic [7:0] CMD_ACK   = 8'hfa,
  parameter int         LEN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           i_pw_wdata,
  input  logic                 i_pw_wcmd,
  input  logic                 i_pw_wstb,
  input  logic                 i_pw_end,
  output logic                 o_pw_req,
  input  logic                 i_pw_gnt,
  output logic [7:0]           o_pw_rdata,
  input  logic                 i_pw_rstb,
  output logic                 o_pw_irq,
  input  logic [31:0]          i_req_file_id,
  input  logic [31:0]          i_req_offset,
  input  logic [LEN_WIDTH-1:0] i_req_len,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [7:0]           i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic                 o_resp_done,
  output logic                 o_resp_err
);
  localparam int IW = LEN_WIDTH + 2;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PEND, S_XFER, S_WAIT_ACK} state_t;
  state_t               r_state;
  logic [31:0]          r_id, r_off;
  logic [LEN_WIDTH-1:0] r_len, r_wcnt;
  logic [IW-1:0]        r_ridx;
  logic                 r_ack_seen, r_pw_req, r_pw_irq, r_req_ready, r_wr_ready, r_resp_done, r_resp_err;
  logic [7:0]           r_mem [0:(1<<LEN_WIDTH)-1];
  logic [7:0]           r_bdata;
  logic                 w_get, w_ack, w_stat, w_wr, w_rd;
  logic [IW-1:0]        w_total, w_ridx_nxt;
  logic [LEN_WIDTH-1:0] w_baddr;
  logic [79:0]          w_hdr;
  logic [7:0]           w_hbyte;
  assign w_get      = i_pw_wstb & i_pw_wcmd & (i_pw_wdata == CMD_GET);
  assign w_ack      = i_pw_wstb & i_pw_wcmd & (i_pw_wdata == CMD_ACK);
  assign w_stat     = i_pw_wstb & ~i_pw_wcmd;
  assign w_wr       = i_wr_valid & r_wr_ready;
  assign w_total    = IW'(r_len) + IW'(11);
  // reads at or past the last byte hold the index so the end is detectable
  assign w_rd       = (r_state == S_XFER) & i_pw_gnt & i_pw_rstb & (r_ridx != w_total);
  assign w_ridx_nxt = r_ridx + IW'(w_rd);
  assign w_hdr      = {r_id, r_off, 16'(r_len)};
  assign w_hbyte    = 8'(w_hdr >> {4'd9 - r_ridx[3:0], 3'b000});
  // buffer read address tracks the read index; data lands one clock later
  assign w_baddr    = LEN_WIDTH'(r_ridx - IW'(10));
  assign o_pw_rdata = (r_ridx < IW'(10)) ? w_hbyte : (r_ridx < w_total) ? r_bdata : 8'h00;
  assign o_pw_req    = r_pw_req;
  assign o_pw_irq    = r_pw_irq;
  assign o_req_ready = r_req_ready;
  assign o_wr_ready  = r_wr_ready;
  assign o_resp_done = r_resp_done;
  assign o_resp_err  = r_resp_err;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wcnt] <= i_wr_data;
    r_bdata <= r_mem[w_baddr];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_off       <= '0;
      r_len       <= '0;
      r_wcnt      <= '0;
      r_ridx      <= '0;
      r_ack_seen  <= 1'b0;
      r_pw_req    <= 1'b0;
      r_pw_irq    <= 1'b0;
      r_req_ready <= 1'b1;
      r_wr_ready  <= 1'b0;
      r_resp_done <= 1'b0;
      r_resp_err  <= 1'b0;
    end else begin
      r_resp_done <= 1'b0;
      r_resp_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: if (i_req_valid & r_req_ready) begin
          r_id        <= i_req_file_id;
          r_off       <= i_req_offset;
          r_len       <= i_req_len;
          r_wcnt      <= '0;
          r_req_ready <= 1'b0;
          r_wr_ready  <= 1'b1;
          r_state     <= S_FILL;
        end
        S_FILL: if (w_wr) begin
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == r_len) begin
            r_wr_ready <= 1'b0;
            r_pw_irq   <= 1'b1;
            r_state    <= S_PEND;
          end
        end
        // a GET coinciding with CS rise is dropped
        S_PEND: if (w_get & ~i_pw_end) begin
          r_pw_irq <= 1'b0;
          r_pw_req <= 1'b1;
          r_ridx   <= '0;
          r_state  <= S_XFER;
        end
        S_XFER: begin
          r_ridx <= w_ridx_nxt;
          if (i_pw_end) begin
            r_pw_req   <= 1'b0;
            r_ack_seen <= 1'b0;
            r_pw_irq   <= (w_ridx_nxt != w_total);
            r_state    <= (w_ridx_nxt == w_total) ? S_WAIT_ACK : S_PEND;
          end
        end
        // the status byte must follow ACK within the same transaction
        S_WAIT_ACK: if (w_stat & r_ack_seen) begin
          r_resp_done <= 1'b1;
          r_resp_err  <= |i_pw_wdata;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end else if (i_pw_end) r_ack_seen <= 1'b0;
        else if (w_ack) r_ack_seen <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
